// File: rtl/seven_seg_scroll_controller.sv
// Scrolls a buffer of segment patterns across eight digits.
// Writes are accepted only while idle; the window wraps at the number of valid entries.
module seven_seg_scroll_controller #(
  parameter int           N     = 8,
  parameter int           DEPTH = 16,
  parameter int           TICKS = 25000000,
  parameter logic [N-1:0] BLANK = 8'hFF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     WrEn,
  input  logic [N-1:0]             WrData,
  input  logic                     Clear,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic                     Pause,
  output logic [N-1:0]             D7,
  output logic [N-1:0]             D6,
  output logic [N-1:0]             D5,
  output logic [N-1:0]             D4,
  output logic [N-1:0]             D3,
  output logic [N-1:0]             D2,
  output logic [N-1:0]             D1,
  output logic [N-1:0]             D0,
  output logic [$clog2(DEPTH):0]   Length,
  output logic                     Full,
  output logic                     Running
);

  localparam int OW = $clog2(DEPTH);
  localparam int LW = OW + 1;
  localparam int TW = $clog2(TICKS);
  localparam int PW = OW + 4;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_next_s;
  logic [N-1:0]  msg_r [DEPTH];
  logic [LW-1:0] length_r, length_next_s;
  logic          full_r;
  logic          running_r;
  logic [OW-1:0] offset_r, offset_next_s;
  logic [TW-1:0] tick_r, tick_next_s;
  logic          wr_s;
  logic [PW-1:0] pos_s    [8];
  logic [OW-1:0] idx_s    [8];
  logic [N-1:0]  window_s [8];
  logic [N-1:0]  disp_r   [8];

  // Next state, buffer length and scroll position
  always_comb begin
    state_next_s  = state_r;
    length_next_s = length_r;
    offset_next_s = offset_r;
    tick_next_s   = tick_r;
    wr_s          = 1'b0;
    case (state_r)
      IDLE: begin
        offset_next_s = '0;
        tick_next_s   = '0;
        if (Start && !Stop && (length_r != '0)) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
        // Clear wins over a simultaneous write
        if (Clear) begin
          length_next_s = '0;
        end else if (WrEn && !full_r) begin
          wr_s          = 1'b1;
          length_next_s = length_r + LW'(1);
        end else begin
          length_next_s = length_r;
        end
      end
      RUN: begin
        if (Stop) begin
          state_next_s  = IDLE;
          offset_next_s = '0;
          tick_next_s   = '0;
        end else if (!Pause) begin
          if (tick_r == TICK_LAST) begin
            tick_next_s = '0;
            if (LW'(offset_r) == (length_r - LW'(1))) begin
              offset_next_s = '0;
            end else begin
              offset_next_s = offset_r + OW'(1);
            end
          end else begin
            tick_next_s = tick_r + TW'(1);
          end
        end else begin
          tick_next_s   = tick_r;
          offset_next_s = offset_r;
        end
      end
      default: begin
        state_next_s  = IDLE;
        length_next_s = '0;
        offset_next_s = '0;
        tick_next_s   = '0;
      end
    endcase
  end

  // Eight-character window starting at offset, wrapping at the valid length
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pos_s[k] = PW'(offset_r) + PW'(k);
      if (length_r != '0) begin
        idx_s[k] = OW'(pos_s[k] % PW'(length_r));
      end else begin
        idx_s[k] = '0;
      end
      window_s[k] = msg_r[idx_s[k]];
    end
  end

  // Control state, length, flags and scroll position
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= IDLE;
      length_r  <= '0;
      full_r    <= 1'b0;
      running_r <= 1'b0;
      offset_r  <= '0;
      tick_r    <= '0;
    end else begin
      state_r   <= state_next_s;
      length_r  <= length_next_s;
      full_r    <= (length_next_s == LW'(DEPTH));
      running_r <= (state_next_s == RUN);
      offset_r  <= offset_next_s;
      tick_r    <= tick_next_s;
    end
  end

  // Message storage is intentionally left unreset; Length masks stale entries
  always_ff @(posedge Clock) begin
    if (!Reset && wr_s) begin
      msg_r[length_r[OW-1:0]] <= WrData;
    end
  end

  // Display register: one cycle behind the state that selects it
  always_ff @(posedge Clock) begin
    for (int k = 0; k < 8; k++) begin
      if (Reset) begin
        disp_r[k] <= BLANK;
      end else if (state_r == RUN) begin
        disp_r[k] <= window_s[k];
      end else begin
        disp_r[k] <= BLANK;
      end
    end
  end

  assign D7      = disp_r[0];
  assign D6      = disp_r[1];
  assign D5      = disp_r[2];
  assign D4      = disp_r[3];
  assign D3      = disp_r[4];
  assign D2      = disp_r[5];
  assign D1      = disp_r[6];
  assign D0      = disp_r[7];
  assign Length  = length_r;
  assign Full    = full_r;
  assign Running = running_r;

endmodule

// File: tb/tb_seven_seg_scroll_controller.sv
// Scoreboard bench: driver pushes expected outputs from a message-queue model,
// monitor pops and compares one cycle's outputs after every rising edge.
module tb_seven_seg_scroll_controller;

  localparam int TICKS = 4;
  localparam int DEPTH = 16;

  logic       Clock, Reset, WrEn, Clear, Start, Stop, Pause;
  logic [7:0] WrData;
  logic [7:0] D7, D6, D5, D4, D3, D2, D1, D0;
  logic [4:0] Length;
  logic       Full, Running;

  seven_seg_scroll_controller #(.N(8), .DEPTH(DEPTH), .TICKS(TICKS), .BLANK(8'hFF)) dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrData(WrData), .Clear(Clear),
    .Start(Start), .Stop(Stop), .Pause(Pause),
    .D7(D7), .D6(D6), .D5(D5), .D4(D4), .D3(D3), .D2(D2), .D1(D1), .D0(D0),
    .Length(Length), .Full(Full), .Running(Running)
  );

  typedef struct packed {
    logic [63:0] disp;
    logic [4:0]  len;
    logic        full;
    logic        run;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: a queue of messages plus a scrolling flag, offset and tick count
  logic [7:0] msg[$];
  bit         m_run  = 1'b0;
  int         m_off  = 0;
  int         m_tick = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic drive(input bit rst, input bit wr, input logic [7:0] wd, input bit clr,
                       input bit st, input bit sp, input bit ps);
    exp_t e;
    @(negedge Clock);
    Reset = rst; WrEn = wr; WrData = wd; Clear = clr; Start = st; Stop = sp; Pause = ps;
    e.disp = {64{1'b1}};
    if (!rst && m_run) begin
      for (int k = 0; k < 8; k++) e.disp[63-8*k -: 8] = msg[(m_off + k) % msg.size()];
    end
    if (rst) begin
      msg.delete(); m_run = 1'b0; m_off = 0; m_tick = 0;
    end else if (m_run) begin
      if (sp) begin
        m_run = 1'b0; m_off = 0; m_tick = 0;
      end else if (!ps) begin
        m_tick = m_tick + 1;
        if (m_tick == TICKS) begin
          m_tick = 0;
          m_off  = (m_off + 1) % msg.size();
        end
      end
    end else begin
      if (st && !sp && msg.size() > 0) begin
        m_run = 1'b1; m_off = 0; m_tick = 0;
      end
      if (clr) msg.delete();
      else if (wr && msg.size() < DEPTH) msg.push_back(wd);
    end
    e.len  = 5'(msg.size());
    e.full = (msg.size() == DEPTH);
    e.run  = m_run;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic pause_for(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0, 0, 1);
  endtask

  // Monitor: compares the outputs after each edge against the oldest expectation
  always @(posedge Clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({D7, D6, D5, D4, D3, D2, D1, D0} !== mon_e.disp) begin
        errors++;
        $display("FAIL digits got %h want %h at %0t", {D7, D6, D5, D4, D3, D2, D1, D0}, mon_e.disp, $time);
      end
      checks++;
      if (Length !== mon_e.len) begin
        errors++;
        $display("FAIL length got %0d want %0d at %0t", Length, mon_e.len, $time);
      end
      checks++;
      if (Full !== mon_e.full) begin
        errors++;
        $display("FAIL full got %b want %b at %0t", Full, mon_e.full, $time);
      end
      checks++;
      if (Running !== mon_e.run) begin
        errors++;
        $display("FAIL running got %b want %b at %0t", Running, mon_e.run, $time);
      end
    end
  end

  initial begin
    bit         r_rst, r_wr, r_clr, r_st, r_sp, r_ps;
    logic [7:0] r_wd;
    Reset = 1'b1; WrEn = 1'b0; WrData = 8'h00; Clear = 1'b0;
    Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    idle(2);

    // Ten entries, scroll past the wrap point
    for (int i = 1; i <= 10; i++) drive(0, 1, 8'(i), 0, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 0, 0);
    idle(45);
    drive(0, 0, 8'h00, 0, 0, 1, 0);
    idle(2);

    // Overfill: writes beyond DEPTH are dropped
    drive(0, 0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 8'(8'h40 + i), 0, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 0, 0);
    idle(70);
    drive(0, 0, 8'h00, 0, 0, 1, 0);

    // Three entries repeat cyclically; pause mid-step; Start and Stop together
    drive(0, 0, 8'h00, 1, 0, 0, 0);
    drive(0, 1, 8'h0A, 0, 0, 0, 0);
    drive(0, 1, 8'h0B, 0, 0, 0, 0);
    drive(0, 1, 8'h0C, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 0, 0);
    idle(6);
    pause_for(10);
    idle(8);
    drive(0, 1, 8'h77, 1, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 1, 0);
    idle(2);

    // Start with an empty buffer stays idle
    drive(0, 0, 8'h00, 1, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 0, 0);
    idle(3);

    // Single entry, reset mid-run, then write+clear together
    drive(0, 1, 8'h5A, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 0, 0);
    idle(5);
    drive(1, 1, 8'h33, 0, 0, 0, 0);
    idle(2);
    drive(0, 1, 8'h11, 0, 0, 0, 0);
    drive(0, 1, 8'h22, 1, 0, 0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_clr = ($urandom_range(0, 39) == 0);
      r_wr  = ($urandom_range(0, 2) == 0);
      r_wd  = 8'($urandom);
      r_st  = ($urandom_range(0, 14) == 0);
      r_sp  = ($urandom_range(0, 59) == 0);
      r_ps  = ($urandom_range(0, 7) == 0);
      if (r_st) begin
        r_wr  = 1'b0;
        r_clr = 1'b0;
      end
      drive(r_rst, r_wr, r_wd, r_clr, r_st, r_sp, r_ps);
    end
    idle(2);

    @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
